// File: rtl/srt_div_if.sv
// Operand/result handshake bundle for srt_div_sequencer.
// The master side feeds operand pairs and consumes results; the slave side is the divider.
interface srt_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [3:0]  flags;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, flags
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, flags
  );
endinterface

// File: rtl/srt_div_sequencer.sv
// Radix-2 SRT single-precision divide sequencer: 24 redundant-digit iterations, one
// conversion cycle through an external post-normaliser, truncating, flush-to-zero.
module srt_div_sequencer #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  srt_div_if.slave    bus,
  output logic [23:0] pp_result,
  output logic [4:0]  pp_shift_nums,
  output logic        pp_right_shift,
  output logic        pp_resultsign,
  output logic [7:0]  pp_exponent,
  input  logic [31:0] pp_quotient
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic signed [26:0] w;       // partial remainder, 25 fraction bits
  logic [24:0]        d;       // divisor in [0.5,1), 25 fraction bits
  logic [23:0]        q_pos;
  logic [23:0]        q_neg;
  logic signed [9:0]  e;
  logic               sign;
  logic [31:0]        quotient_q;
  logic [3:0]         flags_q;
  logic [23:0]        pp_result_q;
  logic [7:0]         pp_exp_q;
  logic               pp_sign_q;

  // Operand decode
  logic [7:0]  exp_a, exp_b;
  logic [22:0] man_a, man_b;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, is_special, res_sign;

  assign exp_a    = bus.dividend[30:23];
  assign man_a    = bus.dividend[22:0];
  assign exp_b    = bus.divisor[30:23];
  assign man_b    = bus.divisor[22:0];
  assign res_sign = bus.dividend[31] ^ bus.divisor[31];

  // Exponent 0 covers both true zeros and subnormals, which are flushed.
  assign a_zero = (exp_a == 8'h00);
  assign a_inf  = (exp_a == 8'hFF) && (man_a == 23'd0);
  assign a_nan  = (exp_a == 8'hFF) && (man_a != 23'd0);
  assign b_zero = (exp_b == 8'h00);
  assign b_inf  = (exp_b == 8'hFF) && (man_b == 23'd0);
  assign b_nan  = (exp_b == 8'hFF) && (man_b != 23'd0);
  assign is_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

  logic [31:0] spec_q;
  logic [3:0]  spec_f;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    spec_q = {res_sign, 31'd0};
    spec_f = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q = QNAN;
      spec_f = 4'b1000;
    end else if (a_inf) begin
      spec_q = {res_sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_q = {res_sign, 8'hFF, 23'd0};
      spec_f = 4'b0100;
    end
  end

  // Digit selection looks only at 2W truncated to half-unit resolution.
  logic signed [27:0] two_w, d_ext, w_next;
  logic [3:0]         tw;
  logic               q_plus, q_minus;

  always_comb begin
    two_w   = {w, 1'b0};
    d_ext   = {3'b000, d};
    tw      = two_w[27:24];
    q_plus  = ($signed(tw) >= 4'sd1);
    q_minus = ($signed(tw) < -4'sd1);
    if (q_plus)       w_next = two_w - d_ext;
    else if (q_minus) w_next = two_w + d_ext;
    else              w_next = two_w;
  end

  // Redundant-to-binary conversion; a negative final remainder borrows one ulp.
  logic [23:0] q_conv;
  logic        e_ovf, e_unf;
  logic [31:0] conv_word;
  logic [3:0]  conv_flags;

  always_comb begin
    q_conv     = q_pos - q_neg - {23'd0, w[26]};
    e_ovf      = (e >= 10'sd255);
    e_unf      = (e <= 10'sd0) || ((e == 10'sd1) && !q_conv[23]);
    conv_word  = pp_quotient;
    conv_flags = 4'b0000;
    if (e_ovf) begin
      conv_word  = {sign, 8'hFF, 23'd0};
      conv_flags = 4'b0010;
    end else if (e_unf) begin
      conv_word  = {sign, 31'd0};
      conv_flags = 4'b0001;
    end
  end

  assign pp_shift_nums  = 5'd0;
  assign pp_right_shift = 1'b0;
  assign pp_result      = (state == S_CONV) ? q_conv : pp_result_q;
  assign pp_exponent    = (state == S_CONV) ? e[7:0] : pp_exp_q;
  assign pp_resultsign  = (state == S_CONV) ? sign   : pp_sign_q;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.flags     = flags_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 5'd0;
      w           <= '0;
      d           <= '0;
      q_pos       <= '0;
      q_neg       <= '0;
      e           <= '0;
      sign        <= 1'b0;
      quotient_q  <= '0;
      flags_q     <= '0;
      pp_result_q <= '0;
      pp_exp_q    <= '0;
      pp_sign_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          sign <= res_sign;
          if (is_special) begin
            quotient_q <= spec_q;
            flags_q    <= spec_f;
            state      <= S_DONE;
          end else begin
            d     <= {1'b1, man_b, 1'b0};
            w     <= {3'b000, 1'b1, man_a};
            q_pos <= '0;
            q_neg <= '0;
            cnt   <= 5'd0;
            e     <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          w     <= w_next[26:0];
          q_pos <= {q_pos[22:0], q_plus};
          q_neg <= {q_neg[22:0], q_minus};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd23) state <= S_CONV;
        end
        S_CONV: begin
          quotient_q  <= conv_word;
          flags_q     <= conv_flags;
          pp_result_q <= q_conv;
          pp_exp_q    <= e[7:0];
          pp_sign_q   <= sign;
          state       <= S_DONE;
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
